mesh_cfg_sequencer: RTL and testbench
=====================================

MESH_CFG_SEQUENCER -- requirements
Module: mesh_cfg_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CFG_ADDR, 32'h3000_0000, configuration register address.
- STAT_ADDR, 32'h3000_0004, status register address.
- SETTLE_CYCLES, 4, hold cycles after a switch (1..15).
- DRAIN_TIMEOUT, 255, maximum DRAIN cycles (1..255).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- wb_clk_i  in  1  single clock, all logic on its rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  host Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i, wbs_adr_i  in  32 each  write data, address.
- wbs_ack_o  out  1  ack for this block's registers only.
- wbs_dat_o  out  32  read data.
- fab_busy_i  in  1  a fabric cycle is outstanding (issued, not yet acked).
- configuration_o  out  4  routing configuration to the mesh line muxes; values 0..3 only.
- hold_o  out  1  blocks new host cycles into the fabric.
- cfg_changed_o  out  1  one-cycle pulse when configuration_o changes.

Function
REQ-003 The block SHALL decode only CFG_ADDR and STAT_ADDR; other addresses SHALL get no ack.
REQ-004 The ack SHALL be registered: it asserts the cycle after a decoded stb&cyc, lasts exactly one cycle and is low for at least one cycle before the next ack.
REQ-005 A CFG write with sel[0]=1 SHALL latch dat_i[1:0] as pending and set pend_valid; dat_i[3:2]!=0 SHALL set sticky err and leave pending unchanged.
REQ-006 A CFG write equal to the active value while the FSM is in IDLE SHALL be acked without starting a sequence.
REQ-007 A CFG read SHALL return {28'b0, configuration_o}.
- STAT read: [1:0] active, [3:2] pending, [4] busy (FSM not IDLE), [5] err, [6] timeout, others 0.
- A STAT write SHALL clear err and timeout where dat_i bits are 1 (write-1-to-clear).
REQ-008 The FSM SHALL have states IDLE, DRAIN, SWITCH and SETTLE.
REQ-009 IDLE->DRAIN when pend_valid; hold_o SHALL assert in the same cycle as the DRAIN entry.
REQ-010 DRAIN->SWITCH when fab_busy_i=0.
- Alternatively, when the drain counter reaches DRAIN_TIMEOUT; this SHALL also set timeout.
- The counter SHALL be 8 bits, cleared on DRAIN entry, and never wrap.
REQ-011 SWITCH SHALL last one cycle: configuration_o<=pending, cfg_changed_o=1, pend_valid cleared.
REQ-012 SETTLE SHALL count SETTLE_CYCLES cycles, then go to DRAIN if pend_valid was re-set during the sequence, else to IDLE.
REQ-013 hold_o SHALL be 1 in DRAIN, SWITCH and SETTLE, and 0 in IDLE.
REQ-014 A CFG write during DRAIN/SETTLE SHALL overwrite pending (last writer wins).
- If the write lands in the SWITCH cycle, the new value SHALL take priority and pend_valid SHALL stay 1.
REQ-015 Latency SHALL be 2 cycles from the write ack to configuration_o updating when fab_busy_i=0 (DRAIN 1, SWITCH 1).

Reset
REQ-016 With wb_rst_i high at a clock edge, all of the following SHALL be cleared:
- state to IDLE;
- configuration_o, pending, pend_valid, err, timeout, counters;
- hold_o, cfg_changed_o, wbs_ack_o, wbs_dat_o.
REQ-017 Reset mid-sequence SHALL abandon the sequence, with no cfg_changed_o pulse and configuration_o=0.

Structure
REQ-018 Package mesh_cfg_pkg SHALL hold the FSM state enum, default register addresses and STAT bit-position constants.
REQ-019 The drain-timeout/settle counter SHALL be a sub-module mesh_cfg_timer with load, enable, terminal-count output and saturation at its terminal count.

Verification
REQ-020 Write CFG=2, fab_busy_i=0 -> 2 cycles after ack: configuration_o=2, one cfg_changed_o pulse, hold_o high for 2+4 cycles.
REQ-021 Write CFG=1 with fab_busy_i held 10 cycles -> configuration_o unchanged until fab_busy_i falls, then 1; timeout=0.
REQ-022 fab_busy_i stuck 1, write CFG=3 -> switch after 255 DRAIN cycles; STAT[6]=1; STAT write 0x40 clears it.
REQ-023 Write CFG=1, then CFG=3 during SETTLE -> configuration_o 1 then 3, two pulses, hold_o continuous, final IDLE.
REQ-024 Write dat=0x5 -> err=1, no sequence, configuration_o unchanged; assert reset mid-DRAIN -> configuration_o=0, hold_o=0 next cycle.
REQ-025 Read STAT_ADDR+8 -> no ack; back-to-back stb on CFG -> ack never high two consecutive cycles.

Source files
------------

// File: rtl/mesh_cfg_pkg.sv
// Shared types and constants for the mesh routing-configuration sequencer.
// Holds the FSM state enum, default register addresses and STAT field positions.
package mesh_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [31:0] CFG_ADDR_DEF  = 32'h3000_0000;
  localparam logic [31:0] STAT_ADDR_DEF = 32'h3000_0004;

  localparam int STAT_ACT_LSB  = 0;
  localparam int STAT_PEND_LSB = 2;
  localparam int STAT_BUSY_BIT = 4;
  localparam int STAT_ERR_BIT  = 5;
  localparam int STAT_TOUT_BIT = 6;

  localparam int CNT_W = 8;

  function automatic logic [31:0] stat_word(input logic [1:0] act,
                                            input logic [1:0] pend,
                                            input logic       busy,
                                            input logic       err,
                                            input logic       tout);
    logic [31:0] w;
    w = '0;
    w[STAT_ACT_LSB +: 2]  = act;
    w[STAT_PEND_LSB +: 2] = pend;
    w[STAT_BUSY_BIT]      = busy;
    w[STAT_ERR_BIT]       = err;
    w[STAT_TOUT_BIT]      = tout;
    return w;
  endfunction

endpackage

// File: rtl/mesh_cfg_timer.sv
// Shared drain-timeout / settle counter: counts up from zero after a clear and
// saturates at the limit; tc_o flags the cycle whose increment reaches the limit.
module mesh_cfg_timer
  import mesh_cfg_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign tc_o    = en_i && (cnt_inc >= {1'b0, limit_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != limit_i)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mesh_cfg_sequencer.sv
// Wishbone-programmed sequencer that drains the fabric, switches the mesh routing
// configuration and holds new host cycles off until the line muxes have settled.
//
// state     | meaning
// ST_IDLE   | no change pending, host traffic flows
// ST_DRAIN  | hold asserted, waiting for the outstanding fabric cycle or timeout
// ST_SWITCH | one cycle: new configuration applied, cfg_changed pulse
// ST_SETTLE | SETTLE_CYCLES of hold while the muxes settle
module mesh_cfg_sequencer
  import mesh_cfg_pkg::*;
#(
  parameter logic [31:0] CFG_ADDR      = CFG_ADDR_DEF,
  parameter logic [31:0] STAT_ADDR     = STAT_ADDR_DEF,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          DRAIN_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        fab_busy_i,
  output logic [3:0]  configuration_o,
  output logic        hold_o,
  output logic        cfg_changed_o
);

  state_e      state_q;
  logic [1:0]  active_q;
  logic        hold_q;
  logic        changed_q;

  logic [1:0]  pending_q, pending_d;
  logic        pend_valid_q, pend_valid_d;
  logic        err_q, err_d;
  logic        tout_q, tout_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  logic        hit_cfg, hit_stat, accept, cfg_wr, stat_wr, rd_acc;
  logic        go_switch, go_timeout;
  logic        tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_limit;
  logic        unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:7], wbs_dat_i[4]};

  assign hit_cfg  = (wbs_adr_i == CFG_ADDR);
  assign hit_stat = (wbs_adr_i == STAT_ADDR);
  // Blocking on ack_q forces a low cycle between acks even with stb held.
  assign accept   = wbs_stb_i & wbs_cyc_i & (hit_cfg | hit_stat) & ~ack_q;
  assign cfg_wr   = accept & wbs_we_i & hit_cfg & wbs_sel_i[0];
  assign stat_wr  = accept & wbs_we_i & hit_stat & wbs_sel_i[0];
  assign rd_acc   = accept & ~wbs_we_i;

  assign go_switch  = (state_q == ST_DRAIN) & (~fab_busy_i | tmr_tc);
  assign go_timeout = (state_q == ST_DRAIN) & fab_busy_i & tmr_tc;

  assign tmr_en    = (state_q == ST_DRAIN) | (state_q == ST_SETTLE);
  assign tmr_clr   = (state_q == ST_IDLE) | (state_q == ST_SWITCH) |
                     ((state_q == ST_SETTLE) & tmr_tc);
  assign tmr_limit = (state_q == ST_DRAIN) ? CNT_W'(DRAIN_TIMEOUT) : CNT_W'(SETTLE_CYCLES);

  mesh_cfg_timer u_timer (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    err_d        = err_q;
    tout_d       = tout_q;
    ack_d        = accept;
    rdata_d      = '0;

    if (go_switch) pend_valid_d = 1'b0;

    if (stat_wr) begin
      if (wbs_dat_i[STAT_ERR_BIT])  err_d  = 1'b0;
      if (wbs_dat_i[STAT_TOUT_BIT]) tout_d = 1'b0;
    end
    if (go_timeout) tout_d = 1'b1;

    // A write in the switch cycle wins over the clear and triggers another pass.
    if (cfg_wr) begin
      if (wbs_dat_i[3:2] != 2'b00) begin
        err_d = 1'b1;
      end else begin
        pending_d    = wbs_dat_i[1:0];
        pend_valid_d = !((state_q == ST_IDLE) && !pend_valid_q &&
                         (wbs_dat_i[1:0] == active_q));
      end
    end

    if (rd_acc) begin
      rdata_d = hit_cfg ? {30'b0, active_q}
                        : stat_word(active_q, pending_q, state_q != ST_IDLE, err_q, tout_q);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      err_q        <= 1'b0;
      tout_q       <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      err_q        <= err_d;
      tout_q       <= tout_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      hold_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pend_valid_q) begin
            state_q <= ST_DRAIN;
            hold_q  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (go_switch) begin
            state_q   <= ST_SWITCH;
            active_q  <= pending_q;
            changed_q <= 1'b1;
          end
        end
        ST_SWITCH: begin
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_tc) begin
            if (pend_valid_q) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_IDLE;
              hold_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign configuration_o = {2'b00, active_q};
  assign hold_o          = hold_q;
  assign cfg_changed_o   = changed_q;
  assign wbs_ack_o       = ack_q;
  assign wbs_dat_o       = rdata_q;

endmodule

// File: tb/tb_mesh_cfg_sequencer.sv
// Randomized bench for mesh_cfg_sequencer: a transaction-level model predicts
// register contents, switch latency, pulse counts and hold durations.
`timescale 1ns/1ps
module tb_mesh_cfg_sequencer;

  localparam logic [31:0] CFG_A  = 32'h3000_0000;
  localparam logic [31:0] STAT_A = 32'h3000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_w = '0, adr = '0;
  logic        busy = 1'b0;
  logic        ack, hold, chg;
  logic [31:0] dat_r;
  logic [3:0]  cfg;

  int n_checks = 0, n_fail = 0;
  int cyc_n = 0;
  int n_pulse = 0, n_hold = 0, n_rise = 0, n_ack = 0, n_dbl = 0, n_bad = 0;
  int chg_cyc[$];
  logic       ack_p = 1'b0, hold_p = 1'b0;
  logic [3:0] cfg_p = 4'h0;

  logic [1:0] m_act = 2'd0, m_pend = 2'd0;
  logic       m_err = 1'b0, m_tout = 1'b0;

  mesh_cfg_sequencer dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs_stb_i       (stb),
    .wbs_cyc_i       (cyc),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_dat_i       (dat_w),
    .wbs_adr_i       (adr),
    .wbs_ack_o       (ack),
    .wbs_dat_o       (dat_r),
    .fab_busy_i      (busy),
    .configuration_o (cfg),
    .hold_o          (hold),
    .cfg_changed_o   (chg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n = cyc_n + 1;

  always @(negedge clk) begin
    if (chg) n_pulse++;
    if (hold) n_hold++;
    if (hold && !hold_p) n_rise++;
    if (ack) n_ack++;
    if (ack && ack_p) n_dbl++;
    if (cfg > 4'd3) n_bad++;
    if (cfg != cfg_p) chg_cyc.push_back(cyc_n);
    ack_p  = ack;
    hold_p = hold;
    cfg_p  = cfg;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         output logic got, output logic [31:0] rd);
    got = 1'b0;
    rd  = '0;
    adr = a; we = w; dat_w = d; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got = 1'b1;
        rd  = dat_r;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    tick(2);
    while (hold && k < 400) begin
      tick(1);
      k++;
    end
    check_val(tag, 32'(hold), 32'd0);
  endtask

  function automatic logic [31:0] m_stat();
    return {25'b0, m_tout, m_err, 1'b0, m_pend, m_act};
  endfunction

  function automatic int first_chg(input int base);
    if (chg_cyc.size() == 0) return -1;
    return chg_cyc[0] - base;
  endfunction

  task automatic read_stat(input string tag, input logic [31:0] exp);
    logic        got;
    logic [31:0] rd;
    wb_xfer(STAT_A, 1'b0, 32'h0, got, rd);
    check_val({tag, "_ack"}, 32'(got), 32'd1);
    check_val(tag, rd, exp);
  endtask

  initial begin
    logic        got;
    logic [31:0] rd;
    logic [1:0]  v, v1, v2;
    int b, w, sw, a_cyc, h0, p0, r0, k0, d0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_cfg", 32'(cfg), 32'd0);
    check_val("rst_hold", 32'(hold), 32'd0);
    check_val("rst_chg", 32'(chg), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_dat", dat_r, 32'd0);
    read_stat("rst_stat", m_stat());
    wb_xfer(CFG_A, 1'b0, 32'h0, got, rd);
    check_val("rst_cfgrd", rd, 32'd0);

    // Plain switches, with and without an outstanding fabric cycle.
    for (int it = 0; it < 8; it++) begin
      v = 2'($urandom_range(0, 3));
      if (v == m_act) v = v + 2'd1;
      b = (it < 2) ? 0 : $urandom_range(0, 12);
      busy = (b > 0);
      h0 = n_hold; p0 = n_pulse; r0 = n_rise;
      chg_cyc.delete();
      wb_xfer(CFG_A, 1'b1, ($urandom & 32'hFFFF_FFF0) | 32'(v), got, rd);
      check_val("wr_ack", 32'(got), 32'd1);
      a_cyc = cyc_n;
      if (b == 0) begin
        tick(1);
        check_val("lat_pre", 32'(cfg), 32'(m_act));
        tick(1);
        check_val("lat_post", 32'(cfg), 32'(v));
      end else begin
        tick(b);
        busy = 1'b0;
      end
      wait_idle("seq_idle");
      m_act = v;
      m_pend = v;
      sw = (b + 1 > 2) ? b + 1 : 2;
      check_val("chg_lat", 32'(first_chg(a_cyc)), 32'(sw));
      check_val("pulses", 32'(n_pulse - p0), 32'd1);
      check_val("hold_len", 32'(n_hold - h0), 32'(sw + 4));
      check_val("hold_rise", 32'(n_rise - r0), 32'd1);
      check_val("cfg_final", 32'(cfg), 32'(m_act));
      read_stat("seq_stat", m_stat());
    end

    // Fabric stuck busy: drain times out after DRAIN_TIMEOUT cycles.
    v = m_act + 2'd1;
    busy = 1'b1;
    p0 = n_pulse;
    chg_cyc.delete();
    wb_xfer(CFG_A, 1'b1, 32'(v), got, rd);
    a_cyc = cyc_n;
    m_pend = v;
    tick(10);
    read_stat("drain_stat", m_stat() | 32'h10);
    wait_idle("tout_idle");
    m_act = v;
    m_tout = 1'b1;
    check_val("tout_lat", 32'(first_chg(a_cyc)), 32'd256);
    check_val("tout_pulses", 32'(n_pulse - p0), 32'd1);
    read_stat("tout_stat", m_stat());
    busy = 1'b0;
    wb_xfer(STAT_A, 1'b1, 32'h40, got, rd);
    m_tout = 1'b0;
    read_stat("tout_clr", m_stat());

    // Second write during SETTLE queues another full pass.
    for (int it = 0; it < 3; it++) begin
      v1 = 2'($urandom_range(0, 3));
      if (v1 == m_act) v1 = v1 + 2'd1;
      v2 = 2'($urandom_range(0, 3));
      if (v2 == v1) v2 = v2 + 2'd1;
      w = $urandom_range(2, 5);
      h0 = n_hold; p0 = n_pulse; r0 = n_rise;
      chg_cyc.delete();
      wb_xfer(CFG_A, 1'b1, 32'(v1), got, rd);
      a_cyc = cyc_n;
      tick(w);
      wb_xfer(CFG_A, 1'b1, 32'(v2), got, rd);
      wait_idle("settle_idle");
      m_act = v2;
      m_pend = v2;
      check_val("settle_nchg", 32'(chg_cyc.size()), 32'd2);
      check_val("settle_chg1", 32'(first_chg(a_cyc)), 32'd2);
      if (chg_cyc.size() > 1) check_val("settle_chg2", 32'(chg_cyc[1] - a_cyc), 32'd8);
      check_val("settle_pulses", 32'(n_pulse - p0), 32'd2);
      check_val("settle_rise", 32'(n_rise - r0), 32'd1);
      check_val("settle_hold", 32'(n_hold - h0), 32'd12);
      check_val("settle_cfg", 32'(cfg), 32'(m_act));
      read_stat("settle_stat", m_stat());
    end

    // Overwrite during DRAIN: last writer wins, single switch.
    v1 = m_act + 2'd1;
    v2 = v1 + 2'd1;
    busy = 1'b1;
    p0 = n_pulse;
    chg_cyc.delete();
    wb_xfer(CFG_A, 1'b1, 32'(v1), got, rd);
    a_cyc = cyc_n;
    tick(3);
    wb_xfer(CFG_A, 1'b1, 32'(v2), got, rd);
    tick(2);
    busy = 1'b0;
    wait_idle("ovr_idle");
    m_act = v2;
    m_pend = v2;
    check_val("ovr_lat", 32'(first_chg(a_cyc)), 32'd7);
    check_val("ovr_pulses", 32'(n_pulse - p0), 32'd1);
    check_val("ovr_cfg", 32'(cfg), 32'(m_act));

    // Illegal configuration values set err and start nothing.
    for (int it = 0; it < 2; it++) begin
      h0 = n_hold; p0 = n_pulse;
      wb_xfer(CFG_A, 1'b1, ($urandom & 32'hFFFF_FFF0) |
              32'($urandom_range(1, 3) << 2) | 32'($urandom_range(0, 3)), got, rd);
      check_val("err_ack", 32'(got), 32'd1);
      wait_idle("err_idle");
      m_err = 1'b1;
      check_val("err_pulses", 32'(n_pulse - p0), 32'd0);
      check_val("err_hold", 32'(n_hold - h0), 32'd0);
      check_val("err_cfg", 32'(cfg), 32'(m_act));
      read_stat("err_stat", m_stat());
      wb_xfer(STAT_A, 1'b1, 32'h40, got, rd);
      read_stat("err_keep", m_stat());
      wb_xfer(STAT_A, 1'b1, 32'h20, got, rd);
      m_err = 1'b0;
      read_stat("err_clr", m_stat());
    end

    // Writing the active value while idle is acked without a sequence.
    h0 = n_hold; p0 = n_pulse;
    wb_xfer(CFG_A, 1'b1, 32'(m_act), got, rd);
    check_val("same_ack", 32'(got), 32'd1);
    wait_idle("same_idle");
    check_val("same_pulses", 32'(n_pulse - p0), 32'd0);
    check_val("same_hold", 32'(n_hold - h0), 32'd0);

    // Undecoded addresses get no ack.
    wb_xfer(STAT_A + 32'd8, 1'b0, 32'h0, got, rd);
    check_val("noack_stat8", 32'(got), 32'd0);
    wb_xfer(CFG_A + 32'($urandom_range(3, 100) * 4), 1'b1, 32'h1, got, rd);
    check_val("noack_rand", 32'(got), 32'd0);
    check_val("noack_cfg", 32'(cfg), 32'(m_act));

    // Strobe held on CFG: acks alternate.
    k0 = n_ack; d0 = n_dbl;
    tick(1);
    adr = CFG_A; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    tick(10);
    stb = 1'b0; cyc = 1'b0;
    tick(2);
    check_val("b2b_acks", 32'(n_ack - k0), 32'd5);
    check_val("b2b_double", 32'(n_dbl - d0), 32'd0);

    // Reset in the middle of DRAIN.
    if (m_act == 2'd0) begin
      wb_xfer(CFG_A, 1'b1, 32'd2, got, rd);
      wait_idle("pre_rst_idle");
      m_act = 2'd2;
      m_pend = 2'd2;
    end
    v = m_act + 2'd1;
    busy = 1'b1;
    p0 = n_pulse;
    wb_xfer(CFG_A, 1'b1, 32'(v), got, rd);
    tick(3);
    check_val("mid_hold", 32'(hold), 32'd1);
    check_val("mid_cfg", 32'(cfg), 32'(m_act));
    rst = 1'b1;
    tick(1);
    check_val("mrst_cfg", 32'(cfg), 32'd0);
    check_val("mrst_hold", 32'(hold), 32'd0);
    check_val("mrst_chg", 32'(chg), 32'd0);
    rst = 1'b0;
    busy = 1'b0;
    m_act = 2'd0; m_pend = 2'd0; m_err = 1'b0; m_tout = 1'b0;
    tick(10);
    check_val("mrst_pulses", 32'(n_pulse - p0), 32'd0);
    check_val("mrst_hold2", 32'(hold), 32'd0);
    read_stat("mrst_stat", m_stat());

    check_val("cfg_range", 32'(n_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
